// File: rtl/execute_port1_issue_buffer_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// execute_port1_issue_buffer_if
//   Bundles the scheduler-side handshake, the ALU1-side dispatch bus and the
//   status/control lines of the execute port 1 issue buffer.
//
//   master : scheduler / ALU1 environment (drives the i* signals)
//   slave  : the issue buffer itself (drives the o* signals)
//
//   iFREE_EX          synchronous pipeline flush
//   iSCHE_VALID       scheduler presents a micro-op
//   iSCHE_PAYLOAD     100-bit packed micro-op
//   oSCHE_BUSY        buffer full, scheduler must hold
//   oEX_ALU1_VALID    head entry dispatched to ALU1 this cycle
//   oEX_ALU1_PAYLOAD  head entry contents
//   iEX_ALU1_LOCK     ALU1 writeback occupied by a divider result
//   iDIV_RETIRE       one-cycle pulse per divider result leaving ALU1
//   oCOUNT            occupied entries
//   oDIV_INFLIGHT     divides dispatched and not yet retired
// ----------------------------------------------------------------------------
interface execute_port1_issue_buffer_if #(
    parameter int DEPTH_N = 2
) ();
    logic               iFREE_EX;
    logic               iSCHE_VALID;
    logic [99:0]        iSCHE_PAYLOAD;
    logic               oSCHE_BUSY;
    logic               oEX_ALU1_VALID;
    logic [99:0]        oEX_ALU1_PAYLOAD;
    logic               iEX_ALU1_LOCK;
    logic               iDIV_RETIRE;
    logic [DEPTH_N:0]   oCOUNT;
    logic [4:0]         oDIV_INFLIGHT;

    modport master (
        output iFREE_EX, iSCHE_VALID, iSCHE_PAYLOAD, iEX_ALU1_LOCK, iDIV_RETIRE,
        input  oSCHE_BUSY, oEX_ALU1_VALID, oEX_ALU1_PAYLOAD, oCOUNT, oDIV_INFLIGHT
    );

    modport slave (
        input  iFREE_EX, iSCHE_VALID, iSCHE_PAYLOAD, iEX_ALU1_LOCK, iDIV_RETIRE,
        output oSCHE_BUSY, oEX_ALU1_VALID, oEX_ALU1_PAYLOAD, oCOUNT, oDIV_INFLIGHT
    );
endinterface

// File: rtl/execute_port1_issue_buffer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// execute_port1_issue_buffer
//   In-order FIFO between scheduler 1 and execute port 1 (ALU1). Micro-ops
//   are written on iSCHE_VALID while not busy and presented from the head.
//   Non-divide heads wait for ALU1's lock to clear; divide heads ignore the
//   lock but are held once DIV_MAX divides are outstanding so the divider's
//   condition FIFO cannot overflow. iFREE_EX empties the buffer.
//
//   Ports:
//     iCLOCK   clock
//     iRESET   asynchronous active-high reset
//     bus      execute_port1_issue_buffer_if.slave (handshake, payloads,
//              lock, divide retire, flush, occupancy and divide counters)
//
//   Payload layout (bit 99 is a spare bit, stored and passed through):
//     [98] writeback   [97:92] commit_tag  [91:87] cmd   [86:83] afe
//     [82] sys_reg     [81] logic  [80] shift  [79] adder  [78] mul
//     [77] sdiv        [76] udiv
//     [75:44] source0  [43:12] source1
//     [11] dest_sysreg [10:5] dest_regname [4] flags_wb [3:0] flags_regname
// ----------------------------------------------------------------------------
module execute_port1_issue_buffer #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2,
    parameter int DIV_MAX = 16
) (
    input logic                         iCLOCK,
    input logic                         iRESET,
    execute_port1_issue_buffer_if.slave bus
);
    localparam int PW       = 100;
    localparam int SDIV_BIT = 77;
    localparam int UDIV_BIT = 76;

    logic [PW-1:0]      mem_q [DEPTH];
    logic [DEPTH_N-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_N-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_N:0]   count_q, count_d;
    logic [4:0]         divInflight_q, divInflight_d;

    logic               empty;
    logic               full;
    logic               headDiv;
    logic               doWrite;
    logic               doDispatch;
    logic               divInc;
    logic               divDec;
    logic [PW-1:0]      headEntry;

    assign headEntry = mem_q[rdPtr_q];

    // Divides bypass the lock (ALU1 accepts them while its divider drains,
    // and the lock itself comes from divide issue) but respect the cap.
    // Dispatch is still evaluated during a flush; ALU1 drops that op itself.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == (DEPTH_N+1)'(DEPTH));
        headDiv    = headEntry[SDIV_BIT] | headEntry[UDIV_BIT];
        doWrite    = bus.iSCHE_VALID && !full && !bus.iFREE_EX;
        doDispatch = !empty && (headDiv ? (divInflight_q < 5'(DIV_MAX))
                                        : !bus.iEX_ALU1_LOCK);
    end

    assign bus.oSCHE_BUSY       = full;
    assign bus.oEX_ALU1_VALID   = doDispatch;
    assign bus.oEX_ALU1_PAYLOAD = headEntry;
    assign bus.oCOUNT           = count_q;
    assign bus.oDIV_INFLIGHT    = divInflight_q;

    // Flush wins over everything; a retire with nothing outstanding is a
    // no-op so the divide counter never wraps below zero.
    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        divInflight_d = divInflight_q;
        divInc        = doDispatch && headDiv;
        divDec        = bus.iDIV_RETIRE && (divInflight_q != '0);

        if (bus.iFREE_EX) begin
            wrPtr_d       = '0;
            rdPtr_d       = '0;
            count_d       = '0;
            divInflight_d = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (doDispatch) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({doWrite, doDispatch})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case ({divInc, divDec})
                2'b10:   divInflight_d = divInflight_q + 1'b1;
                2'b01:   divInflight_d = divInflight_q - 1'b1;
                default: divInflight_d = divInflight_q;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            divInflight_q <= '0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            divInflight_q <= divInflight_d;
        end
    end

    // Storage is only written at the write pointer; the head is never
    // bypassed from the input, so a new entry is visible one cycle later.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doWrite) begin
            mem_q[wrPtr_q] <= bus.iSCHE_PAYLOAD;
        end
    end
endmodule

// File: tb/tb_execute_port1_issue_buffer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_execute_port1_issue_buffer
//   Directed, table-driven bench for execute_port1_issue_buffer. Each vector
//   holds the inputs for one cycle and the outputs expected during that
//   cycle; multi-cycle corner cases are built as hand-written loops.
// ----------------------------------------------------------------------------
module tb_execute_port1_issue_buffer;
    localparam int KL = 0;
    localparam int KU = 1;
    localparam int KS = 2;

    typedef struct {
        logic       valid;
        logic [5:0] tag;
        logic [1:0] kind;
        logic       lock;
        logic       retire;
        logic       flush;
        logic       expValid;
        logic [5:0] expTag;
        logic [1:0] expKind;
        logic       expBusy;
        logic [2:0] expCount;
        logic [4:0] expDiv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertions = 0;
    int   failures   = 0;

    execute_port1_issue_buffer_if #(.DEPTH_N(2)) bus ();

    execute_port1_issue_buffer #(
        .DEPTH   (4),
        .DEPTH_N (2),
        .DIV_MAX (16)
    ) dut (
        .iCLOCK (clk),
        .iRESET (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input int valid, input int tag, input int kind,
                               input int lock, input int retire, input int flush,
                               input int eValid, input int eTag, input int eKind,
                               input int eBusy, input int eCount, input int eDiv);
        vec_t v;
        v.valid    = 1'(valid);
        v.tag      = 6'(tag);
        v.kind     = 2'(kind);
        v.lock     = 1'(lock);
        v.retire   = 1'(retire);
        v.flush    = 1'(flush);
        v.expValid = 1'(eValid);
        v.expTag   = 6'(eTag);
        v.expKind  = 2'(eKind);
        v.expBusy  = 1'(eBusy);
        v.expCount = 3'(eCount);
        v.expDiv   = 5'(eDiv);
        return v;
    endfunction

    // Distinct, tag-derived contents in every field so reordering or
    // corruption anywhere in the word is visible.
    function automatic logic [99:0] mkPayload(input logic [5:0] tag, input logic [1:0] kind);
        logic [99:0] p;
        p          = '0;
        p[99]      = tag[0];
        p[98]      = 1'b1;
        p[97:92]   = tag;
        p[91:87]   = tag[4:0];
        p[86:83]   = tag[3:0];
        p[81]      = (kind == 2'(KL));
        p[77]      = (kind == 2'(KS));
        p[76]      = (kind == 2'(KU));
        p[75:44]   = {26'h0, tag} ^ 32'hA5A5_0000;
        p[43:12]   = ~{26'h0, tag};
        p[10:5]    = tag;
        p[3:0]     = ~tag[3:0];
        return p;
    endfunction

    task automatic checkVal(input string name, input logic [99:0] act, input logic [99:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.iSCHE_VALID   = v.valid;
        bus.iSCHE_PAYLOAD = mkPayload(v.tag, v.kind);
        bus.iEX_ALU1_LOCK = v.lock;
        bus.iDIV_RETIRE   = v.retire;
        bus.iFREE_EX      = v.flush;
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        checkVal({name, ".valid"}, 100'(bus.oEX_ALU1_VALID), 100'(v.expValid));
        checkVal({name, ".busy"},  100'(bus.oSCHE_BUSY),     100'(v.expBusy));
        checkVal({name, ".count"}, 100'(bus.oCOUNT),         100'(v.expCount));
        checkVal({name, ".div"},   100'(bus.oDIV_INFLIGHT),  100'(v.expDiv));
        if (v.expValid) begin
            checkVal({name, ".payload"}, bus.oEX_ALU1_PAYLOAD, mkPayload(v.expTag, v.expKind));
        end
    endtask

    task automatic step(input string name, input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(name, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        int   kPrev;

        applyStimulus(V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkVal("reset.valid",   100'(bus.oEX_ALU1_VALID), 100'(0));
        checkVal("reset.busy",    100'(bus.oSCHE_BUSY),     100'(0));
        checkVal("reset.count",   100'(bus.oCOUNT),         100'(0));
        checkVal("reset.div",     100'(bus.oDIV_INFLIGHT),  100'(0));
        checkVal("reset.payload", bus.oEX_ALU1_PAYLOAD,     100'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: each op dispatches the cycle after its write
        tbl.push_back(V(1, 1, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));
        tbl.push_back(V(1, 2, KL, 0, 0, 0, 1, 1, KL, 0, 1, 0));
        tbl.push_back(V(1, 3, KL, 0, 0, 0, 1, 2, KL, 0, 1, 0));
        tbl.push_back(V(1, 4, KL, 0, 0, 0, 1, 3, KL, 0, 1, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 4, KL, 0, 1, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));
        // Locked fill to full, fifth write dropped, then drain in order
        tbl.push_back(V(1, 1, KL, 1, 0, 0, 0, 0, KL, 0, 0, 0));
        tbl.push_back(V(1, 2, KL, 1, 0, 0, 0, 0, KL, 0, 1, 0));
        tbl.push_back(V(1, 3, KL, 1, 0, 0, 0, 0, KL, 0, 2, 0));
        tbl.push_back(V(1, 4, KL, 1, 0, 0, 0, 0, KL, 0, 3, 0));
        tbl.push_back(V(1, 5, KL, 1, 0, 0, 0, 0, KL, 1, 4, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 1, KL, 1, 4, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 2, KL, 0, 3, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 3, KL, 0, 2, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 4, KL, 0, 1, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));
        // Divide passes the lock, the younger logic op waits for it
        tbl.push_back(V(1, 7, KU, 1, 0, 0, 0, 0, KL, 0, 0, 0));
        tbl.push_back(V(1, 8, KL, 1, 0, 0, 1, 7, KU, 0, 1, 0));
        tbl.push_back(V(0, 0, KL, 1, 0, 0, 0, 0, KL, 0, 1, 1));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 1, 8, KL, 0, 1, 1));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 1));
        tbl.push_back(V(0, 0, KL, 0, 1, 0, 0, 0, KL, 0, 0, 1));
        // Retire with nothing outstanding is ignored
        tbl.push_back(V(0, 0, KL, 0, 1, 0, 0, 0, KL, 0, 0, 0));
        tbl.push_back(V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Seventeen divides back to back; the seventeenth hits the cap
        for (int i = 0; i < 17; i++) begin
            kPrev = ((i - 1) % 2 == 1) ? KS : KU;
            step($sformatf("divIssue[%0d]", i),
                 V(1, i + 1, (i % 2 == 1) ? KS : KU, 0, 0, 0,
                   (i > 0) ? 1 : 0, i, (i > 0) ? kPrev : KU, 0,
                   (i > 0) ? 1 : 0, (i > 0) ? i - 1 : 0));
        end
        step("divCap",   V(0, 0, KL, 0, 0, 0, 0, 0,  KL, 0, 1, 16));
        step("divRet",   V(0, 0, KL, 0, 1, 0, 0, 0,  KL, 0, 1, 16));
        step("div17",    V(0, 0, KL, 0, 0, 0, 1, 17, KU, 0, 1, 15));
        step("divAfter", V(0, 0, KL, 0, 0, 0, 0, 0,  KL, 0, 0, 16));
        step("flushDiv", V(0, 0, KL, 0, 0, 1, 0, 0,  KL, 0, 0, 16));

        // Three queued entries and five divides outstanding, then flush with a write
        for (int j = 0; j < 5; j++) begin
            step($sformatf("flushSetup[%0d]", j),
                 V(1, 20 + j, KU, 0, 0, 0, (j > 0) ? 1 : 0, 19 + j, KU, 0,
                   (j > 0) ? 1 : 0, (j > 0) ? j - 1 : 0));
        end
        step("flushSetup[5]", V(1, 30, KL, 1, 0, 0, 1, 24, KU, 0, 1, 4));
        step("flushSetup[6]", V(1, 31, KL, 1, 0, 0, 0, 0,  KL, 0, 1, 5));
        step("flushSetup[7]", V(1, 32, KL, 1, 0, 0, 0, 0,  KL, 0, 2, 5));
        step("flushCycle",    V(1, 40, KL, 1, 0, 1, 0, 0,  KL, 0, 3, 5));
        step("flushAfter",    V(0, 0,  KL, 0, 0, 0, 0, 0,  KL, 0, 0, 0));
        step("flushIdle",     V(0, 0,  KL, 0, 0, 0, 0, 0,  KL, 0, 0, 0));

        // Divide dispatch and retire in the same cycle leave the count at 3
        for (int k = 0; k < 4; k++) begin
            step($sformatf("retSame[%0d]", k),
                 V(1, 50 + k, KU, 0, 0, 0, (k > 0) ? 1 : 0, 49 + k, KU, 0,
                   (k > 0) ? 1 : 0, (k > 0) ? k - 1 : 0));
        end
        step("retSame[4]", V(0, 0, KL, 0, 1, 0, 1, 53, KU, 0, 1, 3));
        step("retSame[5]", V(0, 0, KL, 0, 0, 0, 0, 0,  KL, 0, 0, 3));

        // Reset asserted between clock edges clears everything at once
        step("midRst[0]", V(1, 60, KL, 1, 0, 0, 0, 0, KL, 0, 0, 3));
        step("midRst[1]", V(1, 61, KL, 1, 0, 0, 0, 0, KL, 0, 1, 3));
        applyStimulus(V(0, 0, KL, 1, 0, 0, 0, 0, KL, 0, 0, 0));
        rst = 1'b1;
        #1;
        checkVal("midRst.count",   100'(bus.oCOUNT),        100'(0));
        checkVal("midRst.div",     100'(bus.oDIV_INFLIGHT), 100'(0));
        checkVal("midRst.valid",   100'(bus.oEX_ALU1_VALID), 100'(0));
        checkVal("midRst.payload", bus.oEX_ALU1_PAYLOAD,    100'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("postRst", V(0, 0, KL, 0, 0, 0, 0, 0, KL, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/execute_port1_issue_buffer.md
Name: execute_port1_issue_buffer

Overview:
- Issue-side buffer sitting directly upstream of execute port 1 (ALU1: logic/shift/adder/mul plus pipelined radix-2 divider).
- Accepts micro-ops from scheduler 1 via a valid/busy handshake and holds them in a DEPTH-entry in-order FIFO.
- Presents the head entry to ALU1, honouring ALU1's lock and capping in-flight divides so the divider's condition FIFO can never overflow.
- Flushed by iFREE_EX.

Parameters:
- DEPTH, 4, FIFO entries (power of two).
- DEPTH_N, 2, log2(DEPTH).
- DIV_MAX, 16, maximum divides in flight in ALU1 (matches the divider condition FIFO depth).

Ports:
- iCLOCK  in  1  clock.
- iRESET  in  1  asynchronous, active-high reset.
- iFREE_EX  in  1  synchronous pipeline flush.
- iSCHE_VALID  in  1  scheduler presents a micro-op.
- iSCHE_PAYLOAD  in  100  packed micro-op, MSB..LSB:
  - writeback[1], commit_tag[6], cmd[5], afe[4], sys_reg[1], logic[1], shift[1], adder[1], mul[1], sdiv[1], udiv[1]
  - source0[32], source1[32], dest_sysreg[1], dest_regname[6], flags_wb[1], flags_regname[4].
- oSCHE_BUSY  out  1  buffer cannot accept this cycle.
- oEX_ALU1_VALID  out  1  head dispatched to ALU1 this cycle.
- oEX_ALU1_PAYLOAD  out  100  head entry, same field map.
- iEX_ALU1_LOCK  in  1  ALU1 lock (divider result occupying writeback).
- iDIV_RETIRE  in  1  one-cycle pulse when ALU1 emits a divider result.
- oCOUNT  out  DEPTH_N+1  occupied entries.
- oDIV_INFLIGHT  out  5  divides dispatched and not yet retired.

Behaviour:
- Reset (iRESET=1, asynchronous):
  - Pointers and count cleared; div counter cleared.
  - oEX_ALU1_VALID=0, oSCHE_BUSY=0, oCOUNT=0, oDIV_INFLIGHT=0.
  - Payload storage cleared to 0.
- Write: iSCHE_VALID && !oSCHE_BUSY → entry stored at write pointer on the clock edge.
  - Visible at the head no earlier than the next cycle; no combinational bypass.
- oSCHE_BUSY = (count == DEPTH), combinational from registered count.
  - A write in a full cycle is dropped even if a dispatch occurs in the same cycle; the scheduler holds and retries.
- head_div = head.sdiv | head.udiv.
- Dispatch rule:
  - oEX_ALU1_VALID = !empty && (head_div ? (div_inflight < DIV_MAX) : !iEX_ALU1_LOCK).
  - Divides ignore lock: ALU1 accepts divides while its divider is outputting, and ALU1's lock is derived from divide issue. This also breaks the combinational loop through the lock.
  - No ready from ALU1: an asserted oEX_ALU1_VALID always consumes the head on that edge.
- oEX_ALU1_PAYLOAD is driven from head storage at all times; it is only meaningful while oEX_ALU1_VALID=1.
- Count and pointers:
  - count' = count + write − dispatch.
  - Pointers are DEPTH_N bits and wrap modulo DEPTH.
  - Simultaneous write and dispatch when not full leaves count unchanged.
- Div counter:
  - +1 on a dispatched divide; −1 on iDIV_RETIRE.
  - Both in the same cycle → unchanged.
  - iDIV_RETIRE at 0 is ignored (saturates, no underflow).
  - Never exceeds DIV_MAX by construction.
- Flush (iFREE_EX=1 at a clock edge):
  - Pointers, count and div counter go to 0; any write that cycle is dropped.
  - oEX_ALU1_VALID is still evaluated combinationally in the flush cycle. ALU1 discards that op because it flushes on the same iFREE_EX.
  - Flush has priority over write, dispatch and retire.
- Ordering: strictly in order. A blocked head (locked, or divide at the cap) blocks all younger entries.
- Reset asserted mid-operation: all state clears immediately, asynchronously; in-flight content is lost with no partial dispatch.

Test Plan:
- Reset, then write 4 non-div ops (tags 1..4) on consecutive cycles with no lock → oEX_ALU1_VALID high for 4 cycles starting the cycle after the first write, tags 1,2,3,4 in order; oCOUNT never exceeds 1.
- Hold iEX_ALU1_LOCK=1 and write 5 ops → oCOUNT=4, oSCHE_BUSY=1, 5th write dropped; release lock → tags 1..4 dispatch on 4 consecutive cycles and busy deasserts after the first dispatch.
- Lock=1 with a divide (udiv=1, tag 7) at the head → divide dispatches despite lock; a following logic op (tag 8) waits until lock=0.
- Issue 16 divides with no retire → oDIV_INFLIGHT=16 and the 17th is held; pulse iDIV_RETIRE → 17th dispatches the next cycle and oDIV_INFLIGHT stays 16.
- Buffer at 3 entries with div_inflight=5; assert iFREE_EX together with iSCHE_VALID → next cycle oCOUNT=0, oDIV_INFLIGHT=0, oEX_ALU1_VALID=0.
- Pulse iDIV_RETIRE with div_inflight=0 → stays 0; dispatch a divide in the same cycle as a retire at div_inflight=3 → stays 3.
